// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the negedge-clocked 5-stage MIPS pipeline.
// Shadows EX/MEM/WB register usage; drives forwarding, stalls, bubbles, flushes.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset_n,
  input  logic              D_valid,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic              D_uses_rs,
  input  logic              D_uses_rt,
  input  logic [REG_AW-1:0] D_dest,
  input  logic              D_reg_write,
  input  logic              D_mem_read,
  input  logic              D_multi,
  input  logic              BR_taken,
  output logic              PC_en,
  output logic              FD_en,
  output logic              FD_flush,
  output logic              DE_bubble,
  output logic              EX_hold,
  output logic              EM_bubble,
  output logic [1:0]        FWD_a,
  output logic [1:0]        FWD_b,
  output logic [CNT_W-1:0]  STALL_cnt,
  output logic [CNT_W-1:0]  FLUSH_cnt
);

  localparam logic [1:0] LC_INIT    = 2'(LOAD_LAT - 1);
  localparam logic [3:0] BC_INIT    = 4'(MDU_LAT - 1);
  localparam logic       MDU_STALLS = (MDU_LAT > 1);

  logic              ex_v, mem_v, wb_v;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic              ex_ur, ex_ut, ex_rw, ex_mr, ex_multi;
  logic              mem_rw, mem_mr, wb_rw;
  logic [1:0]        lc;
  logic [3:0]        bc;

  logic busy, br_ok, luse, stall_ld, adv_d;
  logic mem_src_ok, wb_src_ok;

  assign busy     = ex_v & ex_multi & (bc != 4'd0);
  assign br_ok    = BR_taken & ex_v & ~busy;
  assign luse     = D_valid & ex_v & ex_mr & ex_rw & (ex_dest != '0) &
                    ((D_uses_rs & (D_rs == ex_dest)) | (D_uses_rt & (D_rt == ex_dest)));
  assign stall_ld = luse | (lc != 2'd0);
  assign adv_d    = ~busy & ~br_ok & ~stall_ld;

  // Loads in EX/MEM have no data yet, so only non-load producers forward from there.
  assign mem_src_ok = mem_v & mem_rw & ~mem_mr & (mem_dest != '0);
  assign wb_src_ok  = wb_v & wb_rw & (wb_dest != '0);

  assign FWD_a = (ex_ur & mem_src_ok & (mem_dest == ex_rs)) ? 2'b10 :
                 (ex_ur & wb_src_ok  & (wb_dest  == ex_rs)) ? 2'b01 : 2'b00;
  assign FWD_b = (ex_ut & mem_src_ok & (mem_dest == ex_rt)) ? 2'b10 :
                 (ex_ut & wb_src_ok  & (wb_dest  == ex_rt)) ? 2'b01 : 2'b00;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    PC_en     = 1'b1;
    FD_en     = 1'b1;
    FD_flush  = 1'b0;
    DE_bubble = 1'b0;
    EX_hold   = 1'b0;
    EM_bubble = 1'b0;
    if (busy) begin
      PC_en     = 1'b0;
      FD_en     = 1'b0;
      EX_hold   = 1'b1;
      EM_bubble = 1'b1;
    end else if (br_ok) begin
      FD_flush  = 1'b1;
      DE_bubble = 1'b1;
    end else if (stall_ld) begin
      PC_en     = 1'b0;
      FD_en     = 1'b0;
      DE_bubble = 1'b1;
    end
  end

  // Control state: valids, load/busy counters.
  always_ff @(negedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      ex_v  <= 1'b0;
      mem_v <= 1'b0;
      wb_v  <= 1'b0;
      lc    <= 2'd0;
      bc    <= 4'd0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      wb_v <= mem_v;
      if (busy) begin
        mem_v <= 1'b0;
        bc    <= bc - 4'd1;
      end else begin
        mem_v <= ex_v;
        if (br_ok) begin
          ex_v <= 1'b0;
          lc   <= 2'd0;
        end else if (stall_ld) begin
          ex_v <= 1'b0;
          lc   <= (lc == 2'd0) ? LC_INIT : lc - 2'd1;
        end else begin
          ex_v <= D_valid;
          if (D_valid & D_multi & MDU_STALLS) bc <= BC_INIT;
        end
      end
    end
  end

  // NOTE: payload fields are meaningless while their valid bit is low, so they carry no reset.
  always_ff @(negedge SYS_clk) begin
    wb_dest <= mem_dest;
    wb_rw   <= mem_rw;
    if (!busy) begin
      mem_dest <= ex_dest;
      mem_rw   <= ex_rw;
      mem_mr   <= ex_mr;
    end
    if (adv_d) begin
      ex_rs    <= D_rs;
      ex_rt    <= D_rt;
      ex_ur    <= D_uses_rs;
      ex_ut    <= D_uses_rt;
      ex_dest  <= D_dest;
      ex_rw    <= D_reg_write;
      ex_mr    <= D_mem_read;
      ex_multi <= D_multi;
    end
  end

  always_ff @(negedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      STALL_cnt <= '0;
      FLUSH_cnt <= '0;
    end else begin
      if (!PC_en && (STALL_cnt != '1)) STALL_cnt <= STALL_cnt + CNT_W'(1);
      if (br_ok && (FLUSH_cnt != '1))  FLUSH_cnt <= FLUSH_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage negedge-clocked MIPS pipeline (F/D/EX/MEM/WB).
- Keeps its own shadow copy of EX/MEM/WB register-usage info.
- Generates EX forwarding selects and load-use stalls, with load latency set by parameter.
- Stalls the pipe for multi-cycle EX ops (mul/div) and flushes on taken branches.
- Pipeline registers consume its enable, bubble and flush outputs; saturating perf counters report stalls and flushes.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 1, bubbles inserted on load-use hazard (1..4)
MDU_LAT, 4, EX occupancy of a multi-cycle op in cycles (1..16); 1 = no stall
CNT_W, 16, perf counter width

Ports:
SYS_clk  in  1  system clock; all state updates on negedge
SYS_reset_n  in  1  asynchronous active-low reset
D_valid  in  1  valid instruction in decode
D_rs  in  REG_AW  decode rs
D_rt  in  REG_AW  decode rt
D_uses_rs  in  1  decode reads rs
D_uses_rt  in  1  decode reads rt
D_dest  in  REG_AW  decode destination (rd or rt, already muxed)
D_reg_write  in  1  decode writes a register
D_mem_read  in  1  decode is a load
D_multi  in  1  decode is a multi-cycle EX op
BR_taken  in  1  branch in EX resolved taken
PC_en  out  1  PC update enable
FD_en  out  1  IF/ID register enable
FD_flush  out  1  clear IF/ID to NOP
DE_bubble  out  1  load NOP into ID/EX
EX_hold  out  1  hold ID/EX contents and EX
EM_bubble  out  1  load NOP into EX/MEM
FWD_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
FWD_b  out  2  ALU operand B select, same encoding
STALL_cnt  out  CNT_W  stalled cycles, saturating
FLUSH_cnt  out  CNT_W  branch flushes, saturating

Behaviour:
- Reset (async, SYS_reset_n=0):
  - Shadow valids cleared; load counter lc=0, busy counter bc=0; perf counters 0.
  - Outputs: PC_en=1, FD_en=1; all other outputs 0; FWD_a/FWD_b=00.
- Shadow stages:
  - ex_{v,rs,rt,ur,ut,dest,rw,mr,multi}, mem_{v,dest,rw,mr}, wb_{v,dest,rw}.
  - Normal negedge: D→ex, ex→mem, mem→wb.
  - A bubble (DE_bubble) writes ex_v=0. EM_bubble writes mem_v=0 while ex holds.
- Forwarding (combinational from shadow state), FWD_a:
  - 10 if mem_v & mem_rw & !mem_mr & mem_dest!=0 & ex_ur & mem_dest==ex_rs.
  - Else 01 if wb_v & wb_rw & wb_dest!=0 & ex_ur & wb_dest==ex_rs.
  - Else 00.
  - EX/MEM has priority over MEM/WB. FWD_b is identical using ex_rt/ex_ut.
  - Register 0 is never forwarded. The register file is write-through, so a WB write is visible to D in the same cycle.
- Load-use hazard:
  - luse = D_valid & ex_v & ex_mr & ex_rw & ex_dest!=0 & ((D_uses_rs & D_rs==ex_dest) | (D_uses_rt & D_rt==ex_dest)).
  - stall_ld = luse | (lc!=0).
  - If luse & lc==0: lc <= LOAD_LAT-1. Else if lc!=0: lc <= lc-1.
  - While stall_ld: PC_en=0, FD_en=0, DE_bubble=1.
  - Exactly LOAD_LAT consecutive bubbles are inserted. With LOAD_LAT=1 the consumer then receives FWD=01.
- Multi-cycle EX:
  - Entering EX with D_multi=1 and MDU_LAT>1 loads bc <= MDU_LAT-1.
  - While bc!=0: PC_en=0, FD_en=0, EX_hold=1, EM_bubble=1, DE_bubble=0. Shadow ex holds; mem_v <= 0; bc decrements.
  - The op leaves EX on the cycle after bc reaches 0.
  - Back-to-back multi ops restart bc on entry.
- Branch:
  - BR_taken is honoured only when ex_v & bc==0. It is ignored while EX_hold=1.
  - On honour: FD_flush=1, DE_bubble=1, PC_en=1, FD_en=1 for that cycle.
  - lc <= 0, which cancels any pending load-use stall (the D instruction is wrong-path).
- Priority: EX_hold > BR_taken > load-use stall.
- Perf counters:
  - STALL_cnt +1 per cycle with PC_en=0.
  - FLUSH_cnt +1 per honoured branch.
  - Both saturate at all-ones (no wrap).
- Reset mid-operation (mid-stall or mid-busy): all state and counters clear immediately; outputs return to reset values without waiting for an edge.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 → on sub in EX, FWD_a=10. A second consumer one instruction later gets FWD_a=01. Destination $0 → FWD=00.
- lw $3,0($1) then add $4,$3,$3 with LOAD_LAT=1 → one cycle with PC_en=0, FD_en=0, DE_bubble=1; next cycle add in EX with FWD_a=FWD_b=01; STALL_cnt=1.
- Same sequence with LOAD_LAT=3 → exactly 3 bubble cycles; STALL_cnt=3; FWD=00 when add reaches EX.
- mult in EX with MDU_LAT=4 → EX_hold=EM_bubble=1 for 3 cycles, PC_en=0; the following independent instruction enters EX on cycle 4.
- BR_taken=1 while a load-use stall is pending → FD_flush=1, DE_bubble=1, PC_en=1, lc cleared; FLUSH_cnt=1. BR_taken asserted during EX_hold → ignored.
- Assert SYS_reset_n=0 mid multi-cycle stall → outputs immediately PC_en=1, FD_en=1, others 0, counters 0. Force CNT_W=2 with 5 stalls → STALL_cnt=3 (saturated).
